// File: rtl/cnn_window_mac_pkg.sv
// Shared constants, FSM encoding and output saturation helper for the window MAC.
// Latency 0 (package only); no flow control of its own.
package cnn_window_mac_pkg;

  localparam int KERNEL_SIZE  = 3;
  localparam int WINDOW_SIZE  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int KERNEL_WIDTH = $clog2(KERNEL_SIZE + 1);
  localparam int IDX_W        = $clog2(WINDOW_SIZE);
  localparam int DATA_W       = 32;
  localparam int PROD_W       = 2 * DATA_W;
  localparam int ACC_W        = PROD_W + IDX_W;
  localparam int SHIFT_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Clamp a full-precision value into DATA_W signed, then optionally zero negatives.
  function automatic logic [DATA_W-1:0] sat_relu(input logic [ACC_W-1:0] v, input logic relu_en);
    logic [ACC_W-DATA_W:0] upper;
    logic [DATA_W-1:0]     r;
    upper = v[ACC_W-1:DATA_W-1];
    if ((&upper) || !(|upper)) begin
      r = v[DATA_W-1:0];
    end else if (v[ACC_W-1]) begin
      r = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      r = {1'b0, {(DATA_W-1){1'b1}}};
    end
    if (relu_en && r[DATA_W-1]) begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_mac_tree.sv
// Masked element-wise multiply (window x weights) and a balanced adder tree over registered products.
// Purely combinational; the caller owns the product and sum registers and all flow control.
module cnn_mac_tree
  import cnn_window_mac_pkg::*;
(
  input  logic [WINDOW_SIZE*DATA_W-1:0] window_i,
  input  logic [WINDOW_SIZE*DATA_W-1:0] weights_i,
  input  logic [KERNEL_WIDTH-1:0]       kernel_width_i,
  input  logic [KERNEL_WIDTH-1:0]       kernel_height_i,
  output logic [WINDOW_SIZE*PROD_W-1:0] prod_o,
  input  logic [WINDOW_SIZE*PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]              sum_o
);

  localparam int LEAVES = 2 ** IDX_W;

  logic [ACC_W-1:0] node [1:2*LEAVES-1];

  always_comb begin : mul
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    a      = '0;
    b      = '0;
    prod_o = '0;
    for (int n = 0; n < WINDOW_SIZE; n++) begin
      a = window_i[n*DATA_W +: DATA_W];
      b = weights_i[n*DATA_W +: DATA_W];
      if ((KERNEL_WIDTH'(n / KERNEL_SIZE) < kernel_height_i) &&
          (KERNEL_WIDTH'(n % KERNEL_SIZE) < kernel_width_i)) begin
        prod_o[n*PROD_W +: PROD_W] = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
      end
    end
  end

  // Heap-ordered tree: node i sums children 2i and 2i+1; leaves past WINDOW_SIZE stay zero.
  always_comb begin : tree
    for (int i = 1; i < 2 * LEAVES; i++) begin
      node[i] = '0;
    end
    for (int n = 0; n < WINDOW_SIZE; n++) begin
      node[LEAVES+n] = {{(ACC_W-PROD_W){prod_i[n*PROD_W+PROD_W-1]}}, prod_i[n*PROD_W +: PROD_W]};
    end
    for (int i = LEAVES - 1; i >= 1; i--) begin
      node[i] = node[2*i] + node[2*i+1];
    end
  end

  assign sum_o = node[1];

endmodule

// File: rtl/cnn_window_mac.sv
// KxK window MAC with bias, shift, ReLU and saturation; 3-cycle latency, one window per cycle.
// Whole pipeline freezes while a result waits for out_ready; window_stall reflects that freeze.
module cnn_window_mac
  import cnn_window_mac_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [KERNEL_WIDTH-1:0]       kernel_width_i,
  input  logic [KERNEL_WIDTH-1:0]       kernel_height_i,
  input  logic [SHIFT_W-1:0]            shift_i,
  input  logic                          relu_en_i,
  input  logic [DATA_W-1:0]             bias_i,
  input  logic                          w_valid,
  input  logic [IDX_W-1:0]              w_idx,
  input  logic [DATA_W-1:0]             w_data,
  input  logic [WINDOW_SIZE*DATA_W-1:0] window,
  input  logic                          window_valid,
  input  logic                          window_finish,
  output logic                          window_stall,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          busy,
  output logic                          done
);

  state_t                          state_q, state_d;
  logic                            done_q, done_d;
  logic [DATA_W-1:0]               w_q [WINDOW_SIZE];
  logic [WINDOW_SIZE*DATA_W-1:0]   weights;
  logic [WINDOW_SIZE*PROD_W-1:0]   prod, s1_prod_q;
  logic [ACC_W-1:0]                sum, s2_sum_q;
  logic                            s1_vld_q, s2_vld_q, out_vld_q;
  logic [DATA_W-1:0]               out_dat_q;
  logic                            en, accept;
  logic signed [ACC_W-1:0]         biased, shifted;

  assign en           = ~out_vld_q | out_ready;
  assign window_stall = ~en;
  assign accept       = window_valid & en & (state_q == ST_RUN);
  assign out_valid    = out_vld_q;
  assign out_data     = out_dat_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;

  always_comb begin
    weights = '0;
    for (int n = 0; n < WINDOW_SIZE; n++) begin
      weights[n*DATA_W +: DATA_W] = w_q[n];
    end
  end

  cnn_mac_tree u_tree (
    .window_i        (window),
    .weights_i       (weights),
    .kernel_width_i  (kernel_width_i),
    .kernel_height_i (kernel_height_i),
    .prod_o          (prod),
    .prod_i          (s1_prod_q),
    .sum_o           (sum)
  );

  assign biased  = s2_sum_q + {{(ACC_W-DATA_W){bias_i[DATA_W-1]}}, bias_i};
  assign shifted = biased >>> shift_i;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (window_finish && !accept) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!s1_vld_q && !s2_vld_q && !out_vld_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < WINDOW_SIZE; n++) w_q[n] <= '0;
    end else if (w_valid && state_q == ST_IDLE) begin
      for (int n = 0; n < WINDOW_SIZE; n++) begin
        if (w_idx == IDX_W'(n)) w_q[n] <= w_data;
      end
    end
  end

  // All three stages advance together so a stalled result never gets overtaken or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      s1_prod_q <= '0;
      s2_sum_q  <= '0;
      out_dat_q <= '0;
    end else if (en) begin
      s1_vld_q  <= accept;
      s2_vld_q  <= s1_vld_q;
      out_vld_q <= s2_vld_q;
      if (accept)   s1_prod_q <= prod;
      if (s1_vld_q) s2_sum_q  <= sum;
      if (s2_vld_q) out_dat_q <= sat_relu(shifted, relu_en_i);
    end
  end

endmodule

// File: tb/tb_cnn_window_mac.sv
// Directed-vector bench for cnn_window_mac: stimulus pushes expected results, a monitor pops and compares.
module tb_cnn_window_mac;
  import cnn_window_mac_pkg::*;

  localparam int WIN = WINDOW_SIZE;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic [KERNEL_WIDTH-1:0] kernel_width_i, kernel_height_i;
  logic [SHIFT_W-1:0]      shift_i;
  logic                    relu_en_i;
  logic [DATA_W-1:0]       bias_i;
  logic                    w_valid;
  logic [IDX_W-1:0]        w_idx;
  logic [DATA_W-1:0]       w_data;
  logic [WIN*DATA_W-1:0]   window;
  logic                    window_valid, window_finish, window_stall;
  logic                    out_valid, out_ready, busy, done;
  logic [DATA_W-1:0]       out_data;

  cnn_window_mac dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .kernel_width_i(kernel_width_i), .kernel_height_i(kernel_height_i),
    .shift_i(shift_i), .relu_en_i(relu_en_i), .bias_i(bias_i),
    .w_valid(w_valid), .w_idx(w_idx), .w_data(w_data),
    .window(window), .window_valid(window_valid), .window_finish(window_finish),
    .window_stall(window_stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   rcv_cnt = 0;
  int   last_out_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      rcv_cnt++;
      last_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("result_queue_nonempty", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.dat);
        if (e.cyc >= 0) chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int idx, input logic [31:0] v);
    w_valid = 1'b1;
    w_idx   = IDX_W'(idx);
    w_data  = v;
    tick();
    w_valid = 1'b0;
  endtask

  task automatic wr_all(input logic [31:0] v);
    for (int i = 0; i < WIN; i++) wr_w(i, v);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [WIN*DATA_W-1:0] fill(input logic [31:0] v);
    logic [WIN*DATA_W-1:0] r;
    for (int i = 0; i < WIN; i++) r[i*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  // Holds the window until it is taken; the expected result is queued at the accept cycle.
  task automatic send_win(input logic [WIN*DATA_W-1:0] w, input logic [31:0] ex, input bit lat);
    exp_t e;
    bit   acc;
    int   n;
    window       = w;
    window_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = !window_stall;
      if (acc) begin
        e.dat = ex;
        e.cyc = lat ? cyc + 3 : -1;
        exp_q.push_back(e);
      end
      tick();
      n++;
    end
    window_valid = 1'b0;
    if (!acc) chk("window_accept_timeout", 0, 1);
  endtask

  task automatic run_finish(input bit chk_cyc);
    bit got;
    int n;
    int pulses;
    window_finish = 1'b1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        chk("busy_low_with_done", 32'(busy), 0);
        if (chk_cyc) chk("done_cycle", cyc, last_out_cyc + 2);
      end
      n++;
    end
    if (!got) chk("done_timeout", 0, 1);
    pulses = got ? 1 : 0;
    repeat (3) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("done_single_pulse", pulses, 1);
    tick();
    window_finish = 1'b0;
  endtask

  task automatic arith_pass(input logic [31:0] wv, input logic [31:0] wn, input logic [31:0] b,
                            input logic [5:0] sh, input logic re, input logic [31:0] ex);
    bias_i    = b;
    shift_i   = sh;
    relu_en_i = re;
    wr_all(wv);
    do_start();
    send_win(fill(wn), ex, 1'b0);
    run_finish(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [WIN*DATA_W-1:0] w;
    int r0;
    int n;

    rst_n = 1'b0; start = 1'b0; kernel_width_i = 2'd3; kernel_height_i = 2'd3;
    shift_i = '0; relu_en_i = 1'b0; bias_i = '0; w_valid = 1'b0; w_idx = '0; w_data = '0;
    window = '0; window_valid = 1'b0; window_finish = 1'b0; out_ready = 1'b1;

    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_window_stall", 32'(window_stall), 0);
    chk("rst_out_data", out_data, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Identity kernel: only the centre weight is 1, so the result is element 4 = 14.
    wr_w(4, 32'd1);
    do_start();
    for (int i = 0; i < WIN; i++) w[i*DATA_W +: DATA_W] = 32'(10 + i);
    send_win(w, 32'd14, 1'b1);
    run_finish(1'b0);

    // 2x2 mask: outside elements carry large values that must be ignored.
    kernel_width_i = 2'd2; kernel_height_i = 2'd2;
    wr_all(32'd1);
    do_start();
    for (int i = 0; i < WIN; i++)
      w[i*DATA_W +: DATA_W] = ((i / 3) < 2 && (i % 3) < 2) ? 32'd5 : 32'(100 + i);
    send_win(w, 32'd20, 1'b0);
    send_win(fill(32'd5), 32'd20, 1'b0);
    send_win(fill(-32'sd3), 32'hFFFF_FFF4, 1'b0);
    run_finish(1'b0);
    kernel_width_i = 2'd3; kernel_height_i = 2'd3;

    // Backpressure: output held off for 5 cycles while 4 windows stream in.
    do_start();
    r0 = rcv_cnt;
    fork
      begin
        for (int k = 1; k <= 4; k++) send_win(fill(32'(k)), 32'(9 * k), 1'b0);
      end
      begin
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("bp_out_valid_pending", 32'(out_valid), 1);
        chk("bp_window_stall", 32'(window_stall), 1);
        tick();
        out_ready = 1'b1;
      end
    join
    run_finish(1'b0);
    chk("bp_result_count", rcv_cnt - r0, 4);

    arith_pass(32'h0010_0000, 32'h0010_0000, 32'd0, 6'd0, 1'b0, 32'h7FFF_FFFF);
    arith_pass(32'hFFF0_0000, 32'h0010_0000, 32'd0, 6'd0, 1'b1, 32'h0000_0000);
    arith_pass(32'hFFF0_0000, 32'h0010_0000, 32'd0, 6'd0, 1'b0, 32'h8000_0000);
    arith_pass(32'h0000_0000, 32'd0, -32'sd8, 6'd2, 1'b0, 32'hFFFF_FFFE);
    arith_pass(32'd1, 32'd100, 32'd4, 6'd3, 1'b0, 32'd113);
    bias_i = '0; shift_i = '0; relu_en_i = 1'b0;

    // Pass with no windows: done still arrives, nothing is emitted.
    do_start();
    r0 = rcv_cnt;
    run_finish(1'b0);
    chk("zero_win_no_output", rcv_cnt - r0, 0);

    // Completion timing after six windows.
    wr_all(32'd1);
    do_start();
    for (int k = 1; k <= 6; k++) send_win(fill(32'(k)), 32'(9 * k), 1'b0);
    run_finish(1'b1);

    // Async reset with results in flight, then a fresh pass relying on cleared weights.
    do_start();
    out_ready = 1'b0;
    send_win(fill(32'd1), 32'd9, 1'b0);
    send_win(fill(32'd1), 32'd9, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk("inflight_out_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_window_stall", 32'(window_stall), 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    bias_i = 32'd3;
    do_start();
    send_win(fill(32'd7), 32'd3, 1'b0);
    run_finish(1'b0);
    bias_i = '0;

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
